// File: rtl/logistic_pkg.sv
// Shared IEEE-754 field layout, logistic-map constants and the float-to-key-byte
// quantiser used by the key extractor.
package logistic_pkg;

  localparam int FP_EXP_BIAS = 127;
  localparam int SIGN_BIT    = 31;
  localparam int EXP_MSB     = 30;
  localparam int EXP_LSB     = 23;
  localparam int MANT_W      = 23;

  localparam logic [31:0] R_3P95     = 32'h407CCCCD;
  localparam logic [31:0] X0_DEFAULT = 32'h3F4A1CAC;

  typedef struct packed {
    logic       err;
    logic [7:0] key;
  } key8_t;

  // floor(x*256) for x in [0,1); exponents 119..126 need a right shift of 16..23
  function automatic key8_t fp_to_key8(input logic [31:0] x);
    logic        s;
    logic [7:0]  e;
    logic [23:0] sig;
    key8_t       r;
    s   = x[SIGN_BIT];
    e   = x[EXP_MSB:EXP_LSB];
    sig = {1'b1, x[MANT_W-1:0]};
    r   = '{err: 1'b0, key: 8'h00};
    if (e == 8'hFF) begin
      r.err = 1'b1;
    end else if (s) begin
      r.err = (e != 8'h00);
    end else if (e >= 8'(FP_EXP_BIAS)) begin
      r.err = 1'b1;
      r.key = 8'hFF;
    end else if (e >= 8'(FP_EXP_BIAS - 8)) begin
      r.key = 8'(sig >> (8'd142 - e));
    end
    return r;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Synchronous key-byte FIFO with a registered head: the output register always
// holds the oldest entry, or zero when the FIFO is empty.
module key_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = 1;
  localparam logic [PTR_W:0] CNT_FULL = DEPTH;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [WIDTH-1:0] r_head;

  logic             w_do_pop;
  logic             w_do_push;
  logic [PTR_W-1:0] w_rd_nxt;

  assign w_do_pop  = pop & (r_count != '0);
  assign w_do_push = push & ((r_count != CNT_FULL) | w_do_pop);
  assign w_rd_nxt  = r_rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

  // The head register is reloaded with the entry that will be oldest after this edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= w_rd_nxt;
      r_count <= r_count + {{PTR_W{1'b0}}, w_do_push} - {{PTR_W{1'b0}}, w_do_pop};
      if (w_do_pop) begin
        if (r_count == CNT_ONE) r_head <= w_do_push ? wdata : '0;
        else                    r_head <= r_mem[w_rd_nxt];
      end else if (r_count == '0 && w_do_push) begin
        r_head <= wdata;
      end
    end
  end

  assign head  = r_head;
  assign full  = (r_count == CNT_FULL);
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/logistic_key_extractor.sv
// Converts the logistic-map float sample stream into key bytes: drops the initial
// transient, quantises each sample to floor(x*256) and buffers bytes for the cipher.
module logistic_key_extractor
  import logistic_pkg::*;
#(
  parameter int SKIP  = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             range_err,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam int CNT_FW = $clog2(DEPTH) + 1;
  localparam int SKIP_W = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam logic [SKIP_W-1:0] SKIP_N  = SKIP_W'(SKIP);
  localparam logic [CNT_FW-1:0] DEPTH_N = CNT_FW'(DEPTH);

  logic              r_run;
  logic              r_vld_p1;
  logic [7:0]        r_key_p1;
  logic              r_err_p1;
  logic [SKIP_W-1:0] r_skip_cnt;
  logic              r_range_err;
  logic [CNT_W-1:0]  r_sample_cnt;

  key8_t             w_q;
  logic              w_accept;
  logic              w_skipping;
  logic              w_in_ready;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CNT_FW-1:0] w_fifo_count;
  logic [7:0]        w_fifo_head;

  // Reserving a slot for the in-flight byte guarantees the FIFO can never overflow
  assign w_in_ready = r_run & ~w_fifo_full &
                      ((w_fifo_count + {{(CNT_FW-1){1'b0}}, r_vld_p1}) < DEPTH_N);
  assign w_accept   = in_valid & w_in_ready;
  assign w_skipping = (r_skip_cnt < SKIP_N);
  assign w_q        = fp_to_key8(in_data);
  assign w_pop      = out_ready & ~w_fifo_empty;

  // Stage p0 -> p1: decode/quantise the accepted sample, track transient and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run        <= 1'b0;
      r_vld_p1     <= 1'b0;
      r_key_p1     <= '0;
      r_err_p1     <= 1'b0;
      r_skip_cnt   <= '0;
      r_range_err  <= 1'b0;
      r_sample_cnt <= '0;
    end else begin
      r_run    <= 1'b1;
      r_vld_p1 <= w_accept & ~w_skipping;
      r_err_p1 <= w_accept & w_q.err;
      if (w_accept) r_key_p1 <= w_q.key;
      if (w_accept && w_skipping) r_skip_cnt <= r_skip_cnt + 1'b1;
      if (w_accept && r_sample_cnt != '1) r_sample_cnt <= r_sample_cnt + 1'b1;
      r_range_err <= r_range_err | r_err_p1;
    end
  end

  // Stage p1 -> FIFO: the quantised byte lands in the buffer one edge after acceptance
  key_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (r_vld_p1),
    .wdata (r_key_p1),
    .pop   (w_pop),
    .head  (w_fifo_head),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  assign in_ready   = w_in_ready;
  assign out_valid  = ~w_fifo_empty;
  assign out_byte   = w_fifo_head;
  assign range_err  = r_range_err;
  assign sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_logistic_key_extractor.sv
// Randomised bench for three extractor configurations against a queue-based
// reference model that quantises samples with real arithmetic.
module tb_logistic_key_extractor;
  import logistic_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic [2:0]  ir;
  logic [2:0]  ov;
  logic [2:0]  re;
  logic [7:0]  ob0, ob1, ob2;
  logic [15:0] c0, c1;
  logic [2:0]  c2;

  always #5 clk = ~clk;

  logistic_key_extractor #(.SKIP(0), .DEPTH(8), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_byte(ob0), .range_err(re[0]),
    .sample_cnt(c0));

  logistic_key_extractor #(.SKIP(4), .DEPTH(8), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_byte(ob1), .range_err(re[1]),
    .sample_cnt(c1));

  logistic_key_extractor #(.SKIP(2), .DEPTH(2), .CNT_W(3)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_byte(ob2), .range_err(re[2]),
    .sample_cnt(c2));

  int P_SKIP  [3] = '{0, 4, 2};
  int P_DEPTH [3] = '{8, 8, 2};
  int P_CMAX  [3] = '{65535, 65535, 7};

  int         m_run [3];
  int         m_pend[3];
  logic [7:0] m_pbyte[3];
  int         m_errp[3];
  int         m_err [3];
  int         m_skip[3];
  int         m_scnt[3];
  int         m_n   [3];
  int         m_h   [3];
  logic [7:0] m_q   [3][16];
  int         dut_pops[3];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", tag, k, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] ref_key(input logic [31:0] x);
    int  e;
    real v;
    e = int'({24'd0, x[30:23]});
    if (e == 255) return 9'h100;
    if (x[31]) return (e == 0) ? 9'h000 : 9'h100;
    if (e == 0) return 9'h000;
    v = (8388608.0 + real'(x[22:0])) * (2.0 ** (e - 150));
    if (v >= 1.0) return 9'h1FF;
    return {1'b0, 8'($rtoi(v * 256.0))};
  endfunction

  function automatic logic [31:0] rand_sample();
    logic [22:0] m;
    int          c;
    m = 23'($urandom);
    c = $urandom_range(0, 15);
    if (c < 9)   return {1'b0, 8'(119 + $urandom_range(0, 7)), m};
    if (c == 9)  return {1'b0, 8'($urandom_range(0, 118)), m};
    if (c == 10) begin
      case ($urandom_range(0, 7))
        0: return 32'h3F000000;
        1: return 32'h3F7FFFFF;
        2: return 32'h3B800000;
        3: return 32'h3B7FFFFF;
        4: return 32'h00000000;
        5: return 32'h80000000;
        6: return 32'h807FFFFF;
        default: return 32'h00000001;
      endcase
    end
    if (c == 11) return {1'b1, 8'h00, m};
    if (c == 12) return {1'b0, 8'($urandom_range(127, 254)), m};
    if (c == 13) return {1'($urandom), 8'hFF, m};
    if (c == 14) return {1'b1, 8'($urandom_range(1, 254)), m};
    return $urandom;
  endfunction

  function automatic logic [7:0] dut_byte(input int k);
    case (k)
      0: return ob0;
      1: return ob1;
      default: return ob2;
    endcase
  endfunction

  function automatic logic [15:0] dut_cnt(input int k);
    case (k)
      0: return c0;
      1: return c1;
      default: return {13'd0, c2};
    endcase
  endfunction

  function automatic int m_ready(input int k);
    return (m_run[k] != 0 && (m_n[k] + m_pend[k]) < P_DEPTH[k]) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_run[k] = 0; m_pend[k] = 0; m_pbyte[k] = 8'h00; m_errp[k] = 0;
      m_err[k] = 0; m_skip[k] = 0; m_scnt[k] = 0; m_n[k] = 0; m_h[k] = 0;
    end
  endtask

  // Advance the model across one rising edge using the inputs now applied
  task automatic model_edge();
    logic [8:0] r;
    int         acc;
    if (rst) begin
      model_reset();
      return;
    end
    r = ref_key(in_data);
    for (int k = 0; k < 3; k++) begin
      acc = (in_valid && m_ready(k) != 0) ? 1 : 0;
      if (m_n[k] > 0 && out_ready) begin
        m_h[k] = (m_h[k] + 1) % 16;
        m_n[k]--;
      end
      if (m_pend[k] != 0) begin
        m_q[k][(m_h[k] + m_n[k]) % 16] = m_pbyte[k];
        m_n[k]++;
      end
      if (m_errp[k] != 0) m_err[k] = 1;
      m_errp[k]  = (acc != 0 && r[8]) ? 1 : 0;
      m_pend[k]  = (acc != 0 && m_skip[k] >= P_SKIP[k]) ? 1 : 0;
      m_pbyte[k] = r[7:0];
      if (acc != 0 && m_skip[k] < P_SKIP[k]) m_skip[k]++;
      if (acc != 0 && m_scnt[k] < P_CMAX[k]) m_scnt[k]++;
      m_run[k] = 1;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk("in_ready",   k, {31'd0, ir[k]}, m_ready(k));
      chk("out_valid",  k, {31'd0, ov[k]}, (m_n[k] > 0) ? 1 : 0);
      chk("out_byte",   k, {24'd0, dut_byte(k)}, (m_n[k] > 0) ? {24'd0, m_q[k][m_h[k]]} : 0);
      chk("range_err",  k, {31'd0, re[k]}, m_err[k]);
      chk("sample_cnt", k, {16'd0, dut_cnt(k)}, m_scnt[k]);
    end
  endtask

  task automatic cyc(input logic iv, input logic [31:0] d, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    for (int k = 0; k < 3; k++) if (ov[k] && ordy) dut_pops[k]++;
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  // Reset pulse lands strictly between edges; outputs must clear without a clock
  task automatic rst_pulse();
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #1 rst = 1'b0;
  endtask

  logic [31:0] dir_a [6];
  logic [31:0] dir_b [4];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) dut_pops[k] = 0;
    model_reset();
    dir_a = '{X0_DEFAULT, 32'h3F000000, 32'h3F7FFFFF, 32'h3B800000, 32'h3B7FFFFF, 32'h00000000};
    dir_b = '{32'h3F800000, 32'hBF000000, 32'h7FC00000, R_3P95};
    repeat (3) @(negedge clk);
    check_all();
    rst = 1'b0;
    cyc(1'b0, 32'd0, 1'b1);

    // In-range samples, one at a time
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, dir_a[i], 1'b1);
      cyc(1'b0, 32'd0, 1'b1);
      if (i == 0) chk("first_key", 0, {24'd0, ob0}, 32'h000000CA);
    end
    chk("no_err", 0, {31'd0, re[0]}, 0);

    // Out-of-range samples back to back
    for (int i = 0; i < 4; i++) cyc(1'b1, dir_b[i], 1'b1);
    repeat (3) cyc(1'b0, 32'd0, 1'b1);
    chk("err_sticky", 0, {31'd0, re[0]}, 1);

    // Backpressure fill then partial drain
    rst_pulse();
    cyc(1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b1, {1'b0, 8'(119 + $urandom_range(0, 7)), 23'($urandom)}, 1'b0);
    chk("ready_full", 0, {31'd0, ir[0]}, 0);
    repeat (3) cyc(1'b0, 32'd0, 1'b1);
    cyc(1'b0, 32'd0, 1'b0);
    chk("ready_back", 0, {31'd0, ir[0]}, 1);
    repeat (12) cyc(1'b0, 32'd0, 1'b1);

    // Transient removal
    rst_pulse();
    cyc(1'b0, 32'd0, 1'b1);
    for (int k = 0; k < 3; k++) dut_pops[k] = 0;
    repeat (10) cyc(1'b1, 32'h3F000000, 1'b1);
    repeat (4) cyc(1'b0, 32'd0, 1'b1);
    chk("skip_bytes", 1, dut_pops[1], 6);
    chk("skip_cnt", 1, {16'd0, c1}, 10);
    chk("sat_cnt", 2, {29'd0, c2}, 7);

    // Reset while bytes are buffered
    rst_pulse();
    cyc(1'b0, 32'd0, 1'b0);
    repeat (5) cyc(1'b1, X0_DEFAULT, 1'b0);
    cyc(1'b0, 32'd0, 1'b0);
    rst_pulse();
    cyc(1'b0, 32'd0, 1'b0);
    cyc(1'b1, 32'h3F000000, 1'b0);
    cyc(1'b0, 32'd0, 1'b0);
    chk("post_rst_head", 0, {24'd0, ob0}, 32'h00000080);

    // Random traffic with varying backpressure and occasional resets
    for (int blk = 0; blk < 30; blk++) begin
      int vp, rp;
      vp = $urandom_range(1, 4);
      rp = $urandom_range(0, 4);
      for (int i = 0; i < 100; i++) begin
        if ($urandom_range(0, 199) == 0) rst_pulse();
        cyc($urandom_range(0, 3) < vp, rand_sample(), $urandom_range(0, 3) < rp);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
